// File: rtl/ex_mem_stage_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ex_mem_stage_pkg : shared opcodes, default widths and FSM encoding          |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
package ex_mem_stage_pkg;

  localparam int         c_DATA_W_DEF  = 16;
  localparam int         c_REG_AW_DEF  = 4;
  localparam logic [3:0] c_REM_REG_DEF = 4'd15;

  localparam logic [3:0] c_CTRL_ADD = 4'b1111;
  localparam logic [3:0] c_CTRL_SUB = 4'b1110;
  localparam logic [3:0] c_CTRL_MUL = 4'b0001;
  localparam logic [3:0] c_CTRL_DIV = 4'b0010;

  typedef enum logic [0:0] {
    ST_RUN      = 1'b0,
    ST_EXC_WAIT = 1'b1
  } exc_state_e;

  function automatic logic is_addsub(input logic [3:0] ctrl);
    return (ctrl == c_CTRL_ADD) || (ctrl == c_CTRL_SUB);
  endfunction

  function automatic logic is_muldiv(input logic [3:0] ctrl);
    return (ctrl == c_CTRL_MUL) || (ctrl == c_CTRL_DIV);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ex_mem_stage_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ex_mem_stage_if : EX-side inputs and MEM-side outputs of the EX/MEM stage   |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
interface ex_mem_stage_if
  import ex_mem_stage_pkg::*;
#(
  parameter int DATA_W = c_DATA_W_DEF,
  parameter int REG_AW = c_REG_AW_DEF
);
  logic              ex_valid;
  logic [3:0]        CTRL;
  logic [DATA_W-1:0] ALU_Result;
  logic [DATA_W-1:0] Remainder;
  logic              Overflow_flag;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_reg_write;
  logic              ex_mem_read;
  logic              ex_mem_write;
  logic [DATA_W-1:0] ex_store_data;
  logic [DATA_W-1:0] ex_pc;
  logic              mem_stall;
  logic              flush;
  logic              exc_ack;

  logic              mem_valid;
  logic              mem_reg_write;
  logic              mem_rem_write;
  logic              mem_mem_read;
  logic              mem_mem_write;
  logic [DATA_W-1:0] mem_alu_result;
  logic [DATA_W-1:0] mem_remainder;
  logic [DATA_W-1:0] mem_store_data;
  logic [REG_AW-1:0] mem_rd;
  logic              ex_stall;
  logic              exc_req;
  logic [DATA_W-1:0] exc_pc;
  logic [7:0]        exc_count;

  modport master (
    output ex_valid, CTRL, ALU_Result, Remainder, Overflow_flag, ex_rd,
           ex_reg_write, ex_mem_read, ex_mem_write, ex_store_data, ex_pc,
           mem_stall, flush, exc_ack,
    input  mem_valid, mem_reg_write, mem_rem_write, mem_mem_read, mem_mem_write,
           mem_alu_result, mem_remainder, mem_store_data, mem_rd,
           ex_stall, exc_req, exc_pc, exc_count
  );

  modport slave (
    input  ex_valid, CTRL, ALU_Result, Remainder, Overflow_flag, ex_rd,
           ex_reg_write, ex_mem_read, ex_mem_write, ex_store_data, ex_pc,
           mem_stall, flush, exc_ack,
    output mem_valid, mem_reg_write, mem_rem_write, mem_mem_read, mem_mem_write,
           mem_alu_result, mem_remainder, mem_store_data, mem_rd,
           ex_stall, exc_req, exc_pc, exc_count
  );

endinterface
`default_nettype wire

// File: rtl/ex_mem_exc_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ex_mem_exc_fsm : overflow exception detection, request and counter          |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module ex_mem_exc_fsm
  import ex_mem_stage_pkg::*;
#(
  parameter int DATA_W = c_DATA_W_DEF
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              i_ex_valid,
  input  wire logic [3:0]        i_ctrl,
  input  wire logic              i_overflow,
  input  wire logic [DATA_W-1:0] i_ex_pc,
  input  wire logic              i_mem_stall,
  input  wire logic              i_flush,
  input  wire logic              i_exc_ack,
  output logic                   o_exc_wait,
  output logic                   o_exc_take,
  output logic                   o_exc_req,
  output logic [DATA_W-1:0]      o_exc_pc,
  output logic [7:0]             o_exc_count
);

  exc_state_e        r_state;
  exc_state_e        w_state_nxt;
  logic              w_take;
  logic [DATA_W-1:0] r_exc_pc;
  logic [7:0]        r_exc_count;

  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    case (r_state)
      ST_RUN: begin
        // A flushed or stalled instruction never raises an exception
        if (!i_mem_stall && !i_flush && i_ex_valid && i_overflow && is_addsub(i_ctrl)) begin
          w_take      = 1'b1;
          w_state_nxt = ST_EXC_WAIT;
        end
      end
      ST_EXC_WAIT: begin
        if (i_exc_ack) begin
          w_state_nxt = ST_RUN;
        end
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_RUN;
      r_exc_pc    <= '0;
      r_exc_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_take) begin
        r_exc_pc <= i_ex_pc;
        if (r_exc_count != 8'hFF) begin
          r_exc_count <= r_exc_count + 8'd1;
        end
      end
    end
  end

  assign o_exc_wait  = (r_state == ST_EXC_WAIT);
  assign o_exc_req   = (r_state == ST_EXC_WAIT);
  assign o_exc_take  = w_take;
  assign o_exc_pc    = r_exc_pc;
  assign o_exc_count = r_exc_count;

endmodule
`default_nettype wire

// File: rtl/ex_mem_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ex_mem_stage : EX/MEM pipeline register with overflow exception handling    |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module ex_mem_stage
  import ex_mem_stage_pkg::*;
#(
  parameter int                DATA_W  = c_DATA_W_DEF,
  parameter int                REG_AW  = c_REG_AW_DEF,
  parameter logic [REG_AW-1:0] REM_REG = REG_AW'(c_REM_REG_DEF)
) (
  input  wire logic     clk,
  input  wire logic     rst,
  ex_mem_stage_if.slave bus
);

  // Register 0 reads as zero, so it can never receive the remainder
  if (REM_REG == '0) begin : g_rem_reg_check
    $error("REM_REG must not be register 0");
  end

  logic              w_exc_wait;
  logic              w_exc_take;
  logic              w_kill;
  logic              w_capture;
  logic              w_rem_write;

  logic              r_valid;
  logic              r_reg_write;
  logic              r_rem_write;
  logic              r_mem_read;
  logic              r_mem_write;
  logic [DATA_W-1:0] r_alu_result;
  logic [DATA_W-1:0] r_remainder;
  logic [DATA_W-1:0] r_store_data;
  logic [REG_AW-1:0] r_rd;

  ex_mem_exc_fsm #(.DATA_W(DATA_W)) u_exc_fsm (
    .clk         (clk),
    .rst         (rst),
    .i_ex_valid  (bus.ex_valid),
    .i_ctrl      (bus.CTRL),
    .i_overflow  (bus.Overflow_flag),
    .i_ex_pc     (bus.ex_pc),
    .i_mem_stall (bus.mem_stall),
    .i_flush     (bus.flush),
    .i_exc_ack   (bus.exc_ack),
    .o_exc_wait  (w_exc_wait),
    .o_exc_take  (w_exc_take),
    .o_exc_req   (bus.exc_req),
    .o_exc_pc    (bus.exc_pc),
    .o_exc_count (bus.exc_count)
  );

  // While an exception is pending the stage issues bubbles regardless of stall/flush
  assign w_kill      = w_exc_wait || (!bus.mem_stall && (bus.flush || w_exc_take));
  assign w_capture   = !bus.mem_stall && !w_kill;
  assign w_rem_write = bus.ex_valid && bus.ex_reg_write && is_muldiv(bus.CTRL);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid      <= 1'b0;
      r_reg_write  <= 1'b0;
      r_rem_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_alu_result <= '0;
      r_remainder  <= '0;
      r_store_data <= '0;
      r_rd         <= '0;
    end else if (w_kill) begin
      r_valid      <= 1'b0;
      r_reg_write  <= 1'b0;
      r_rem_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
    end else if (w_capture) begin
      r_valid      <= bus.ex_valid;
      r_reg_write  <= bus.ex_valid && bus.ex_reg_write;
      r_rem_write  <= w_rem_write;
      r_mem_read   <= bus.ex_valid && bus.ex_mem_read;
      r_mem_write  <= bus.ex_valid && bus.ex_mem_write;
      r_alu_result <= bus.ALU_Result;
      r_remainder  <= w_rem_write ? bus.Remainder : '0;
      r_store_data <= bus.ex_store_data;
      r_rd         <= bus.ex_rd;
    end
  end

  assign bus.mem_valid      = r_valid;
  assign bus.mem_reg_write  = r_reg_write;
  assign bus.mem_rem_write  = r_rem_write;
  assign bus.mem_mem_read   = r_mem_read;
  assign bus.mem_mem_write  = r_mem_write;
  assign bus.mem_alu_result = r_alu_result;
  assign bus.mem_remainder  = r_remainder;
  assign bus.mem_store_data = r_store_data;
  assign bus.mem_rd         = r_rd;
  assign bus.ex_stall       = bus.mem_stall || w_exc_wait;

endmodule
`default_nettype wire

// File: doc/ex_mem_stage.md
EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 Parameter DATA_W, 16, datapath width of ALU_Result, Remainder, store data and PC.
REQ-002 Parameter REG_AW, 4, register-address width.
REQ-003 Parameter REM_REG, 4'd15, destination register for Remainder on multiply/divide.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 ex_valid  in  1  EX holds a valid instruction this cycle.
REQ-007 CTRL  in  4  ALU operation code of the EX instruction.
REQ-008 ALU_Result, Remainder  in  DATA_W each  ALU outputs.
REQ-009 Overflow_flag  in  1  ALU add/subtract overflow.
REQ-010 ex_rd  in  REG_AW  destination register; ex_reg_write, ex_mem_read, ex_mem_write  in  1 each  control bits.
REQ-011 ex_store_data, ex_pc  in  DATA_W each  store operand and instruction PC.
REQ-012 mem_stall  in  1  MEM not accepting; flush  in  1  kill EX instruction; exc_ack  in  1  exception handled.
REQ-013 mem_valid, mem_reg_write, mem_rem_write, mem_mem_read, mem_mem_write  out  1 each  registered MEM controls.
REQ-014 mem_alu_result, mem_remainder, mem_store_data  out  DATA_W each; mem_rd  out  REG_AW.
REQ-015 ex_stall  out  1  hold EX/upstream; exc_req  out  1; exc_pc  out  DATA_W; exc_count  out  8.

Function
REQ-016 Add = 4'b1111, subtract = 4'b1110, multiply = 4'b0001, divide = 4'b0010; other codes carry no special handling.
REQ-017 FSM states RUN and EXC_WAIT; RUN after reset.
REQ-018 ex_stall SHALL equal mem_stall OR (state == EXC_WAIT), combinationally.
REQ-019 RUN, mem_stall=1: all mem_* outputs hold; no exception detection.
REQ-020 RUN, mem_stall=0, flush=1: next mem_valid=0 and all mem_* control bits 0; flush overrides an EX overflow (no exception).
REQ-021 RUN, mem_stall=0, flush=0, ex_valid=1, Overflow_flag=1, CTRL add/sub: next mem_valid=0, exc_req=1, exc_pc=ex_pc, exc_count+1 (saturate at 255), enter EXC_WAIT.
REQ-022 RUN, mem_stall=0, flush=0, otherwise: capture all EX fields next cycle with 1-cycle latency; mem_valid=ex_valid; control bits gated by ex_valid.
REQ-023 mem_rem_write=1 iff captured valid, ex_reg_write=1 and CTRL multiply/divide; mem_remainder=Remainder, else 0.
REQ-024 EXC_WAIT: mem_valid=0; exc_req=1; exc_pc held; flush and mem_stall ignored.
REQ-025 EXC_WAIT, exc_ack=1: next cycle exc_req=0, state RUN; EX instruction not captured in ack cycle.
REQ-026 exc_ack in RUN has no effect.
REQ-027 Overflow_flag ignored for non-add/sub CTRL and when ex_valid=0.

Reset
REQ-028 rst=1 at clock edge: state RUN, all mem_* outputs 0, exc_req=0, exc_pc=0, exc_count=0; overrides every other input, including mid-EXC_WAIT.
REQ-029 First instruction after rst deasserts is captured normally per REQ-022.

Structure
REQ-030 Shared package holds CTRL opcode constants, DATA_W/REG_AW defaults, REM_REG, and FSM state encoding.
REQ-031 One sub-module, ex_mem_exc_fsm, SHALL own state, exc_req, exc_pc, exc_count; the pipeline register stays in ex_mem_stage.

Verification
REQ-032 Add, ALU_Result=16'h0030, rd=3, reg_write=1 -> next cycle mem_valid=1, mem_alu_result=16'h0030, mem_rd=3, mem_rem_write=0.
REQ-033 Multiply, ALU_Result=16'h0000, Remainder=16'h0001 -> mem_rem_write=1, mem_remainder=16'h0001.
REQ-034 Add, Overflow_flag=1, ex_pc=16'h0040 -> exc_req=1, exc_pc=16'h0040, mem_valid=0, ex_stall=1, exc_count=1; exc_ack 3 cycles later -> exc_req=0 next cycle.
REQ-035 Overflow add together with flush=1 -> no exc_req, mem_valid=0, exc_count unchanged.
REQ-036 mem_stall=1 for 2 cycles with changing EX inputs -> mem_* outputs unchanged, ex_stall=1.
REQ-037 rst=1 during EXC_WAIT -> next cycle exc_req=0, exc_count=0, ex_stall=mem_stall.
